// File: rtl/mbox_pkt_arbiter_pkg.sv
// Shared definitions for the MAILBOX packet arbiter: FSM encoding, byte/word
// geometry of the MAILBOX port and small helpers for header and byte selection.
package mbox_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } mbox_state_e;

    // MAILBOX port geometry
    localparam int MBOX_DW    = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = MBOX_DW * WORD_BYTES;
    localparam int BYTE_IDX_W = 2;

    // Header layout: {source index, word count - 1}
    localparam int HDR_SRC_W = 4;
    localparam int HDR_LEN_W = 4;

    // Index of the last byte of a word
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = 2'd3;

    // Build a header byte from source index and length field
    function automatic logic [MBOX_DW-1:0] make_hdr(
        input logic [HDR_SRC_W-1:0] src,
        input logic [HDR_LEN_W-1:0] len
    );
        return {src, len};
    endfunction

    // Select one byte of a word, least-significant byte at index 0
    function automatic logic [MBOX_DW-1:0] word_byte(
        input logic [WORD_W-1:0]     word,
        input logic [BYTE_IDX_W-1:0] sel
    );
        logic [MBOX_DW-1:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mbox_pkt_arbiter_rr_arb.sv
// Combinational round-robin pick: starting just after ptr_i, return the first
// requester with its request set, as a one-hot grant and a binary index.
// The pointer register itself lives in the caller.
module mbox_rr_arb
    import mbox_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int SUM_W = IDX_W + 1;

    // Scan ptr+1, ptr+2, ... modulo NREQ and take the first set request
    always_comb begin : pick
        logic [SUM_W-1:0] sum_v;
        logic [IDX_W-1:0] cand_v;
        logic             found_v;
        gnt_o   = '0;
        idx_o   = '0;
        found_v = 1'b0;
        sum_v   = '0;
        cand_v  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            // ptr < NREQ and i <= NREQ, so one conditional subtract wraps it
            sum_v = {1'b0, ptr_i} + SUM_W'(i);
            if (sum_v >= SUM_W'(NREQ)) begin
                sum_v = sum_v - SUM_W'(NREQ);
            end else begin
                sum_v = sum_v;
            end
            cand_v = sum_v[IDX_W-1:0];
            if (!found_v && req_i[cand_v]) begin
                found_v       = 1'b1;
                gnt_o[cand_v] = 1'b1;
                idx_o         = cand_v;
            end else begin
                found_v = found_v;
            end
        end
    end

endmodule

// File: rtl/mbox_pkt_arbiter.sv
// Shares the MAILBOX byte-write port between NREQ word-oriented requesters.
// Each grant emits one packet: a header {src, len} then LEN+1 words, LSB first.
// Packets are arbitrated round-robin in IDLE; mbox_full_i freezes the datapath.
module mbox_pkt_arbiter
    import mbox_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LEN_W = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*LEN_W-1:0] len_i,
    input  logic [NREQ*32-1:0]   dat_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      ack_o,
    output logic                 busy_o,
    output logic                 mbox_wr_o,
    output logic [MBOX_DW-1:0]   mbox_do_o,
    input  logic                 mbox_full_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    mbox_state_e             state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        idx_q;
    logic [LEN_W-1:0]        word_cnt_q;
    logic [BYTE_IDX_W-1:0]   byte_cnt_q;
    logic [WORD_W-1:0]       buf_q;
    logic [NREQ-1:0]         gnt_q;
    logic [NREQ-1:0]         ack_q;

    logic [NREQ-1:0]         pick_gnt_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic [LEN_W-1:0]        len_a_s [NREQ];
    logic [WORD_W-1:0]       dat_a_s [NREQ];
    logic                    move_s;
    logic [MBOX_DW-1:0]      do_s;

    // Split the flat per-requester buses into indexable arrays
    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign len_a_s[k] = len_i[LEN_W*k +: LEN_W];
        assign dat_a_s[k] = dat_i[WORD_W*k +: WORD_W];
    end

    mbox_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt_s),
        .idx_o (pick_idx_s)
    );

    // A byte moves only when we are sending and the MAILBOX has room
    assign move_s    = ~mbox_full_i & ((state_q == ST_HDR) | (state_q == ST_DATA));
    assign mbox_wr_o = move_s;
    assign busy_o    = (state_q != ST_IDLE);
    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign mbox_do_o = do_s;

    // Byte mux: header in HDR, current buffered word byte in DATA
    always_comb begin
        do_s = 8'h00;
        case (state_q)
            ST_HDR:  do_s = make_hdr(HDR_SRC_W'(idx_q), HDR_LEN_W'(word_cnt_q));
            ST_DATA: do_s = word_byte(buf_q, byte_cnt_q);
            default: do_s = 8'h00;
        endcase
    end

    // Packet FSM: arbitration, word capture, byte/word counting and grant/ack
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDX_W'(NREQ - 1);
            idx_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
        end else begin
            // ack is a single-cycle pulse, only raised on a word capture
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        idx_q      <= pick_idx_s;
                        word_cnt_q <= len_a_s[pick_idx_s];
                        gnt_q      <= pick_gnt_s;
                        state_q    <= ST_HDR;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (move_s) begin
                        buf_q      <= dat_a_s[idx_q];
                        ack_q      <= gnt_q;
                        byte_cnt_q <= '0;
                        state_q    <= ST_DATA;
                    end else begin
                        state_q    <= ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (move_s) begin
                        if (byte_cnt_q != LAST_BYTE) begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end else if (word_cnt_q != '0) begin
                            buf_q      <= dat_a_s[idx_q];
                            ack_q      <= gnt_q;
                            word_cnt_q <= word_cnt_q - LEN_W'(1);
                            byte_cnt_q <= '0;
                        end else begin
                            // Packet done: the finished requester becomes lowest priority
                            ptr_q   <= idx_q;
                            gnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbox_pkt_arbiter.sv
// Bench for mbox_pkt_arbiter (NREQ=2): a cycle table for the basic packet,
// round-robin and back-pressure timing, then scored multi-cycle sequences.
module tb_mbox_pkt_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  len;
    logic [63:0] dat;
    logic        full;
    logic [1:0]  gnt_o, ack_o;
    logic        busy_o, mbox_wr_o;
    logic [7:0]  mbox_do_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mbox_pkt_arbiter #(.NREQ(2), .LEN_W(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .req_i       (req),
        .len_i       (len),
        .dat_i       (dat),
        .gnt_o       (gnt_o),
        .ack_o       (ack_o),
        .busy_o      (busy_o),
        .mbox_wr_o   (mbox_wr_o),
        .mbox_do_o   (mbox_do_o),
        .mbox_full_i (full)
    );

    // Per-cycle vector: inputs for the cycle, outputs expected in that cycle
    typedef struct packed {
        logic       rst_n;
        logic [1:0] req;
        logic       full;
        logic       busy;
        logic       wr;
        logic [7:0] dout;
        logic [1:0] gnt;
        logic [1:0] ack;
    } vec_t;

    vec_t vq[$];

    // Requester model and byte scoreboard
    logic [31:0] words [2][16];
    logic [3:0]  lens  [2];
    logic [4:0]  wp    [2];
    int          rep   [2];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          acks, exp_acks;

    task automatic add_vec(input logic r, input logic [1:0] q, input logic f,
                           input logic b, input logic w, input logic [7:0] d,
                           input logic [1:0] g, input logic [1:0] a);
        vq.push_back({r, q, f, b, w, d, g, a});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // One cycle of the requester model: react to acks, raise new requests, capture the byte
    task automatic tick(input logic full_v, input logic [1:0] raise_v);
        logic [31:0] w_v;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic kb;
            kb = k[0];
            if (ack_o[kb]) begin
                acks++;
                wp[kb] = wp[kb] + 5'd1;
                if (wp[kb] == ({1'b0, lens[kb]} + 5'd1)) begin
                    if (rep[kb] > 0) begin
                        rep[kb]--;
                        wp[kb] = 5'd0;
                    end else begin
                        req[kb] = 1'b0;
                    end
                end
            end
            if (raise_v[kb]) begin
                req[kb] = 1'b1;
                wp[kb]  = 5'd0;
            end
            w_v = wp[kb][4] ? 32'h0 : words[kb][wp[kb][3:0]];
            if (kb) dat[63:32] = w_v;
            else    dat[31:0]  = w_v;
        end
        len  = {lens[1], lens[0]};
        full = full_v;
        #1;
        if (mbox_wr_o) got.push_back(mbox_do_o);
    endtask

    task automatic push_pkt(input logic kb);
        logic [31:0] w_v;
        exp_q.push_back({3'b000, kb, lens[kb]});
        exp_acks += int'(lens[kb]) + 1;
        for (int w = 0; w <= int'(lens[kb]); w++) begin
            w_v = words[kb][w[3:0]];
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(w_v >> (8 * b)));
        end
    endtask

    task automatic clear_sb();
        got.delete();
        exp_q.delete();
        acks = 0;
        exp_acks = 0;
        rep[0] = 0;
        rep[1] = 0;
    endtask

    // Drive until all requests are served and the arbiter is idle (bounded)
    task automatic run(input string name, input logic [1:0] start, input int freeze_at,
                       input int raise0_at, input int budget);
        int         cyc;
        int         frz;
        logic       raised;
        logic [7:0] frz_do;
        logic       fv;
        logic [1:0] rv;
        cyc = 0; frz = 0; raised = 1'b0; frz_do = 8'h00;
        tick(1'b0, start);
        while (!(req == 2'b00 && busy_o == 1'b0)) begin
            if (cyc >= budget) begin
                checks++;
                fails++;
                $display("FAIL %s timeout actual=%0d cycles required<%0d", name, cyc, budget);
                break;
            end
            fv = (freeze_at >= 0 && got.size() == freeze_at && frz < 3);
            rv = 2'b00;
            if (raise0_at >= 0 && !raised && got.size() == raise0_at) begin
                rv = 2'b01;
                raised = 1'b1;
            end
            tick(fv, rv);
            if (fv) begin
                frz++;
                check({name, "_frz_wr"}, {31'd0, mbox_wr_o}, 32'd0);
                if (frz == 1) frz_do = mbox_do_o;
                else check({name, "_frz_do"}, {24'd0, mbox_do_o}, {24'd0, frz_do});
            end
            cyc++;
        end
        if (freeze_at >= 0) check({name, "_frz_cnt"}, frz, 32'd3);
    endtask

    task automatic check_stream(input string name);
        check({name, "_nbytes"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        check({name, "_acks"}, acks, exp_acks);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; req = 2'b00; full = 1'b0; len = 8'h00; dat = 64'h0;
        for (int k = 0; k < 2; k++) begin
            wp[k] = 5'd0; lens[k] = 4'd0; rep[k] = 0;
            for (int w = 0; w < 16; w++) words[k][w] = 32'h0;
        end
        acks = 0; exp_acks = 0;

        // Table: test 1 (single len=0), test 2 (both requesters), back-pressure in HDR/DATA
        //       rst  req   full busy wr  do     gnt    ack
        add_vec(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'h00, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h11, 2'b01, 2'b01);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h22, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h33, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h44, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h00, 2'b01, 2'b00);
        add_vec(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h11, 2'b01, 2'b01);
        add_vec(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h22, 2'b01, 2'b00);
        add_vec(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h33, 2'b01, 2'b00);
        add_vec(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h44, 2'b01, 2'b00);
        add_vec(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h10, 2'b10, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'hAA, 2'b10, 2'b10);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'hBB, 2'b10, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'hCC, 2'b10, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'hDD, 2'b10, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        add_vec(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01, 2'b00);
        add_vec(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'h00, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h11, 2'b01, 2'b01);
        add_vec(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h22, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h22, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h33, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h44, 2'b01, 2'b00);
        add_vec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);

        // Reset and reset-state check
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_state", {25'd0, busy_o, mbox_wr_o, gnt_o, ack_o}, 32'd0);

        dat = {32'hDDCCBBAA, 32'h44332211};
        len = 8'h00;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            rst_n = v.rst_n;
            req   = v.req;
            full  = v.full;
            #1;
            check($sformatf("vec%0d", i),
                  {17'd0, busy_o, mbox_wr_o, mbox_do_o, gnt_o, ack_o},
                  {17'd0, v.busy, v.wr, v.dout, v.gnt, v.ack});
        end

        // Test 3: len=1 packet with 3 frozen cycles at the third byte
        clear_sb();
        lens[0] = 4'd1; lens[1] = 4'd0;
        words[0][0] = 32'h13121110;
        words[0][1] = 32'h17161514;
        push_pkt(1'b0);
        run("freeze", 2'b01, 2, -1, 100);
        check_stream("freeze");

        // Test 4: req1 streams two packets, req0 arrives mid-packet and gets the next slot
        clear_sb();
        lens[0] = 4'd0; lens[1] = 4'd1;
        words[0][0] = 32'hA3A2A1A0;
        words[1][0] = 32'hB3B2B1B0;
        words[1][1] = 32'hB7B6B5B4;
        rep[1] = 1;
        push_pkt(1'b1);
        push_pkt(1'b0);
        push_pkt(1'b1);
        run("fair", 2'b10, -1, 3, 200);
        check_stream("fair");

        // Test 5: reset during DATA of a len=3 packet
        clear_sb();
        lens[0] = 4'd3; lens[1] = 4'd0;
        for (int w = 0; w < 4; w++) words[0][w] = 32'h50505050 + 32'(w);
        tick(1'b0, 2'b01);
        for (int c = 0; c < 50 && got.size() < 3; c++) tick(1'b0, 2'b00);
        check("rst_mid_in_data", {30'd0, busy_o, mbox_wr_o}, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_after", {27'd0, busy_o, mbox_wr_o, gnt_o, ack_o[0]}, 32'd0);
        clear_sb();
        wp[0] = 5'd0;
        words[1][0] = 32'hCAFEF00D;
        push_pkt(1'b1);
        run("after_rst", 2'b10, -1, -1, 100);
        check("after_rst_hdr", {24'd0, (got.size() > 0) ? got[0] : 8'hFF}, 32'h10);
        check_stream("after_rst");

        // Test 6: len=15 packet, byte stream should count 0x00..0x3F after header 0x0F
        clear_sb();
        lens[0] = 4'd15; lens[1] = 4'd0;
        for (int w = 0; w < 16; w++) words[0][w] = 32'h03020100 + 32'h04040404 * 32'(w);
        push_pkt(1'b0);
        run("len15", 2'b01, -1, -1, 400);
        check("len15_total", got.size(), 32'd65);
        check("len15_ackcnt", acks, 32'd16);
        check_stream("len15");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout actual=hung required=finish");
        $fatal(1, "timeout");
    end

endmodule
